mod_updown_counter: RTL and testbench
=====================================

// Module: mod_updown_counter
//
// PURPOSE
// Parametrised synchronous modulo-N up/down counter. It succeeds the fixed 4-bit
// ripple counter with configurable width and modulus, direction control,
// count enable, parallel load, a terminal-count flag and a registered wrap pulse.
// It serves as a generic timing/sequence counter in datapath and test
// infrastructure. All flops are clocked on the rising edge of clk.
//
// PARAMETERS
// WIDTH      4   counter width in bits
// MODULUS    16  count range 0..MODULUS-1; elaboration error unless 2 <= MODULUS <= 2**WIDTH
// RESET_VAL  0   value of q after reset; elaboration error unless RESET_VAL < MODULUS
//
// PORTS
// clk       in   1      rising-edge clock
// reset     in   1      asynchronous reset, active-high
// en        in   1      count enable; steps q by one per cycle when high
// up        in   1      direction: 1 = increment, 0 = decrement
// load      in   1      synchronous parallel load request
// load_val  in   WIDTH  value to load
// q         out  WIDTH  current count (registered)
// tc        out  1      terminal count (combinational)
// wrap      out  1      one-cycle pulse, registered, one cycle after a wrap edge
// load_err  out  1      one-cycle pulse, registered, after a rejected load
//
// BEHAVIOUR
// - Reset (async assert; release takes effect on the next clk edge):
//   q=RESET_VAL, wrap=0, load_err=0.
// - Priority per edge: reset > load > en > hold.
// - load=1, load_val<MODULUS: q<=load_val. wrap<=0, load_err<=0. en is ignored that cycle.
// - load=1, load_val>=MODULUS: q holds, load_err<=1 for one cycle, wrap<=0.
// - en=1, up=1: if q==MODULUS-1 then q<=0 and wrap<=1; else q<=q+1, wrap<=0.
// - en=1, up=0: if q==0 then q<=MODULUS-1 and wrap<=1; else q<=q-1, wrap<=0.
// - en=0, load=0: q holds, wrap<=0, load_err<=0.
// - tc = en & ~load & ((up & q==MODULUS-1) | (~up & q==0)).
//   tc is high in the cycle whose edge will wrap.
// - wrap is high in the cycle after the wrapping edge, i.e. together with the
//   wrapped q value. Consecutive wraps (e.g. MODULUS=2) give consecutive wrap pulses.
// - Direction may change on any cycle. The new direction applies at the next edge
//   with no bubble.
// - Arithmetic is modulo MODULUS, never modulo 2**WIDTH. q never leaves 0..MODULUS-1.
// - Reset asserted mid-count forces q=RESET_VAL immediately, with no clock needed,
//   and clears pending pulses.
// - Latency: one clk from en/load sampled to new q. Outputs have no other pipeline stage.
//
// TESTING (WIDTH=4, MODULUS=10, RESET_VAL=0, 100 ns clock unless stated)
// 1. reset=1 for 15 ns, then en=1, up=1 for 12 cycles
//    -> q: 0,1..9,0,1.
//    -> tc high only while q=9; wrap high only while q=0 after 9.
// 2. From q=0 with en=1, up=0
//    -> q: 9,8,7.
//    -> tc high while q=0; wrap high while q=9.
// 3. q=5, load=1, load_val=3 with en=1
//    -> q=3 next cycle (load wins).
//    Then load_val=12 -> q stays 3, load_err pulses one cycle.
// 4. en=0 for 5 cycles at q=7, any up -> q holds 7; tc=0, wrap=0.
// 5. Reset pulse 10 ns wide between edges while q=6
//    -> q=0 within the pulse, before the next edge.
//    -> Counting resumes 1,2,... after release.
// 6. MODULUS=2, RESET_VAL=1, en=1, up=1
//    -> q toggles 0,1,0,...
//    -> wrap high every other cycle.
//    -> Rerun with MODULUS=16: full 4-bit wrap 15->0.

Source files
------------

// File: rtl/mod_updown_counter_if.sv
// mod_updown_counter_if
// Control and status bundle for the modulo-N up/down counter.
//   en        count enable (one step per clock while high)
//   up        direction: 1 = increment, 0 = decrement
//   load      synchronous parallel-load request
//   load_val  value to load (rejected when >= MODULUS)
//   q         current count, registered
//   tc        terminal count, combinational: the coming edge will wrap
//   wrap      registered one-cycle pulse, valid together with the wrapped q
//   load_err  registered one-cycle pulse after a rejected load
// The master drives the controls; the slave (the counter) drives the status.
interface mod_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, up, load, load_val,
    input  q, tc, wrap, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output q, tc, wrap, load_err
  );
endinterface

// File: rtl/mod_updown_counter.sv
// mod_updown_counter
// Parametrised modulo-N up/down counter with count enable, parallel load,
// combinational terminal count and registered wrap / load-error pulses.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous reset, active-high: q=RESET_VAL, pulses cleared
//   bus    mod_updown_counter_if.slave (en, up, load, load_val -> q, tc,
//          wrap, load_err)
// Per-edge priority: reset > load > en > hold. All arithmetic is modulo
// MODULUS, so q always stays within 0..MODULUS-1.
module mod_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  mod_updown_counter_if.slave   bus
);

  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if ((RESET_VAL < 0) || (RESET_VAL >= MODULUS)) begin : g_bad_reset_val
    $error("mod_updown_counter: RESET_VAL must satisfy 0 <= RESET_VAL < MODULUS");
  end

  // MODULUS may equal 2**WIDTH, so the range check needs one extra bit.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] Q_RST   = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q;
  logic             wrap;
  logic             load_err;
  logic             at_top;
  logic             at_bottom;
  logic             load_ok;

  assign at_top    = (q == Q_MAX);
  assign at_bottom = (q == '0);
  assign load_ok   = ({1'b0, bus.load_val} < MOD_EXT);

  // Next count for an enabled step, wrapping at the modulus boundary rather
  // than at 2**WIDTH.
  function automatic logic [WIDTH-1:0] step_count(
    input logic [WIDTH-1:0] cur,
    input logic             dir_up
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    if (dir_up) begin
      nxt = (cur == Q_MAX) ? '0 : cur + 1'b1;
    end else begin
      nxt = (cur == '0) ? Q_MAX : cur - 1'b1;
    end
    return nxt;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q        <= Q_RST;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (bus.load) begin
      // A rejected load leaves q untouched and only raises the error pulse.
      if (load_ok) begin
        q <= bus.load_val;
      end
      load_err <= ~load_ok;
      wrap     <= 1'b0;
    end else if (bus.en) begin
      q        <= step_count(q, bus.up);
      wrap     <= bus.up ? at_top : at_bottom;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end
  end

  // tc anticipates the wrap: high in the cycle whose edge will wrap.
  assign bus.tc       = bus.en & ~bus.load &
                        ((bus.up & at_top) | (~bus.up & at_bottom));
  assign bus.q        = q;
  assign bus.wrap     = wrap;
  assign bus.load_err = load_err;

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter
// Table-driven bench for mod_updown_counter. Three instances share clk and
// reset: MODULUS=10 (main table), MODULUS=2 with RESET_VAL=1, and MODULUS=16.
// Each step drives inputs, checks tc before the edge, then checks q, wrap and
// load_err just after the edge.
module tb_mod_updown_counter;

  logic clk;
  logic reset;

  mod_updown_counter_if #(.WIDTH(4)) b10 ();
  mod_updown_counter_if #(.WIDTH(4)) b2  ();
  mod_updown_counter_if #(.WIDTH(4)) b16 ();

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut10 (
    .clk(clk), .reset(reset), .bus(b10)
  );
  mod_updown_counter #(.WIDTH(4), .MODULUS(2), .RESET_VAL(1)) dut2 (
    .clk(clk), .reset(reset), .bus(b2)
  );
  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut16 (
    .clk(clk), .reset(reset), .bus(b16)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic       exp_tc;
    logic [3:0] exp_q;
    logic       exp_wrap;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_fail;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input logic en, input logic up,
                       input logic ld, input logic [3:0] lv);
    case (sel)
      0: begin b10.en = en; b10.up = up; b10.load = ld; b10.load_val = lv; end
      1: begin b2.en  = en; b2.up  = up; b2.load  = ld; b2.load_val  = lv; end
      default: begin b16.en = en; b16.up = up; b16.load = ld; b16.load_val = lv; end
    endcase
  endtask

  task automatic sample(input int sel, output logic [3:0] q, output logic tc,
                        output logic wrap, output logic err);
    case (sel)
      0: begin q = b10.q; tc = b10.tc; wrap = b10.wrap; err = b10.load_err; end
      1: begin q = b2.q;  tc = b2.tc;  wrap = b2.wrap;  err = b2.load_err;  end
      default: begin q = b16.q; tc = b16.tc; wrap = b16.wrap; err = b16.load_err; end
    endcase
  endtask

  // One clock step: inputs applied, tc checked before the edge, registered
  // outputs checked 1 ns after it.
  task automatic step(input int sel, input string tag, input logic en, input logic up,
                      input logic ld, input logic [3:0] lv, input logic etc,
                      input logic [3:0] eq, input logic ew, input logic ee);
    logic [3:0] q;
    logic tc, wr, er;
    drive(sel, en, up, ld, lv);
    #1;
    sample(sel, q, tc, wr, er);
    chk({tag, ".tc"}, {3'b0, tc}, {3'b0, etc});
    @(posedge clk);
    #1;
    sample(sel, q, tc, wr, er);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".wrap"}, {3'b0, wr}, {3'b0, ew});
    chk({tag, ".load_err"}, {3'b0, er}, {3'b0, ee});
  endtask

  function automatic void add(input logic en, input logic up, input logic ld,
                              input logic [3:0] lv, input logic etc,
                              input logic [3:0] eq, input logic ew, input logic ee);
    vec_t v;
    v.en = en; v.up = up; v.load = ld; v.load_val = lv;
    v.exp_tc = etc; v.exp_q = eq; v.exp_wrap = ew; v.exp_err = ee;
    vecs.push_back(v);
  endfunction

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    //  en up ld lv  tc  q  wrap err
    // count up 0..9, wrap to 0, then 1
    add(1, 1, 0, 0,  0, 1, 0, 0);
    add(1, 1, 0, 0,  0, 2, 0, 0);
    add(1, 1, 0, 0,  0, 3, 0, 0);
    add(1, 1, 0, 0,  0, 4, 0, 0);
    add(1, 1, 0, 0,  0, 5, 0, 0);
    add(1, 1, 0, 0,  0, 6, 0, 0);
    add(1, 1, 0, 0,  0, 7, 0, 0);
    add(1, 1, 0, 0,  0, 8, 0, 0);
    add(1, 1, 0, 0,  0, 9, 0, 0);
    add(1, 1, 0, 0,  1, 0, 1, 0);
    add(1, 1, 0, 0,  0, 1, 0, 0);
    // count down 1,0, wrap to 9, then 8,7 (direction change without bubble)
    add(1, 0, 0, 0,  0, 0, 0, 0);
    add(1, 0, 0, 0,  1, 9, 1, 0);
    add(1, 0, 0, 0,  0, 8, 0, 0);
    add(1, 0, 0, 0,  0, 7, 0, 0);
    // hold at 7 for 5 cycles, either direction
    add(0, 1, 0, 0,  0, 7, 0, 0);
    add(0, 0, 0, 0,  0, 7, 0, 0);
    add(0, 1, 0, 0,  0, 7, 0, 0);
    add(0, 0, 0, 0,  0, 7, 0, 0);
    add(0, 1, 0, 0,  0, 7, 0, 0);
    // down to 5, then load wins over en, then rejected load
    add(1, 0, 0, 0,  0, 6, 0, 0);
    add(1, 0, 0, 0,  0, 5, 0, 0);
    add(1, 1, 1, 3,  0, 3, 0, 0);
    add(1, 1, 1, 12, 0, 3, 0, 1);
    add(0, 1, 0, 0,  0, 3, 0, 0);
    // load 9; load while at 9 counting up suppresses tc and wrap
    add(0, 1, 1, 9,  0, 9, 0, 0);
    add(1, 1, 1, 4,  0, 4, 0, 0);
    // load_val exactly MODULUS and the largest 4-bit value are rejected
    add(0, 1, 1, 10, 0, 4, 0, 1);
    add(1, 1, 1, 15, 0, 4, 0, 1);
    add(1, 1, 0, 0,  0, 5, 0, 0);
    // load 6, then a rejected load leaves a pending load_err before reset
    add(0, 1, 1, 6,  0, 6, 0, 0);
    add(0, 1, 1, 12, 0, 6, 0, 1);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0);
    #10;
    chk("reset.q10", b10.q, 4'd0);
    chk("reset.wrap10", {3'b0, b10.wrap}, 4'd0);
    chk("reset.err10", {3'b0, b10.load_err}, 4'd0);
    chk("reset.q2", b2.q, 4'd1);
    chk("reset.q16", b16.q, 4'd0);
    #5;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_release.q10", b10.q, 4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(0, $sformatf("vec%0d", i), vecs[i].en, vecs[i].up, vecs[i].load,
           vecs[i].load_val, vecs[i].exp_tc, vecs[i].exp_q, vecs[i].exp_wrap,
           vecs[i].exp_err);
    end

    // Asynchronous reset between edges: q=6 and load_err pending
    drive(0, 0, 1, 0, 0);
    #20;
    reset = 1'b1;
    #10;
    chk("async_reset.q", b10.q, 4'd0);
    chk("async_reset.err", {3'b0, b10.load_err}, 4'd0);
    chk("async_reset.wrap", {3'b0, b10.wrap}, 4'd0);
    reset = 1'b0;
    step(0, "resume1", 1, 1, 0, 0, 0, 1, 0, 0);
    step(0, "resume2", 1, 1, 0, 0, 0, 2, 0, 0);
    drive(0, 0, 1, 0, 0);

    // MODULUS=2, RESET_VAL=1: toggling, then up/down consecutive wraps
    chk("m2.after_reset", b2.q, 4'd1);
    step(1, "m2.up0", 1, 1, 0, 0, 1, 0, 1, 0);
    step(1, "m2.up1", 1, 1, 0, 0, 0, 1, 0, 0);
    step(1, "m2.up2", 1, 1, 0, 0, 1, 0, 1, 0);
    step(1, "m2.down_wrap", 1, 0, 0, 0, 1, 1, 1, 0);
    step(1, "m2.down", 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, "m2.load_bad3", 1, 0, 1, 3, 0, 0, 0, 1);
    step(1, "m2.load_bad2", 0, 0, 1, 2, 0, 0, 0, 1);
    step(1, "m2.load_ok1", 0, 0, 1, 1, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);

    // MODULUS=16: full 4-bit wrap in both directions, 15 is a legal load
    step(2, "m16.load14", 0, 0, 1, 14, 0, 14, 0, 0);
    step(2, "m16.up15", 1, 1, 0, 0, 0, 15, 0, 0);
    step(2, "m16.wrap_up", 1, 1, 0, 0, 1, 0, 1, 0);
    step(2, "m16.wrap_down", 1, 0, 0, 0, 1, 15, 1, 0);
    step(2, "m16.load15", 0, 0, 1, 15, 0, 15, 0, 0);
    step(2, "m16.hold", 0, 1, 0, 0, 0, 15, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
